// File: rtl/sample_averager_pkg.sv
// Shared parameters for the sample averager: default widths and the accumulator
// width derivation used by the delay line and readout stages as well.
package sample_averager_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_LOG2_AVG   = 4;

  // Summing 2**l2 samples of dw bits needs l2 extra bits and can never overflow.
  function automatic int acc_width(input int dw, input int l2);
    return dw + l2;
  endfunction

endpackage

// File: rtl/sample_averager_if.sv
// Sample-in / result-out bundle of the averager. The master drives samples and
// ready; the slave (the averager) drives the result slot and its status.
interface sample_averager_if
  import sample_averager_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOG2_AVG   = DEF_LOG2_AVG
);
  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, LOG2_AVG);

  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_vld;
  logic                  clear;
  logic [ACC_WIDTH-1:0]  sum_out;
  logic [DATA_WIDTH-1:0] avg_out;
  logic                  avg_out_vld;
  logic                  avg_out_rdy;
  logic                  overrun;
  logic [LOG2_AVG-1:0]   sample_cnt;

  modport master (
    output data_in, data_in_vld, clear, avg_out_rdy,
    input  sum_out, avg_out, avg_out_vld, overrun, sample_cnt
  );

  modport slave (
    input  data_in, data_in_vld, clear, avg_out_rdy,
    output sum_out, avg_out, avg_out_vld, overrun, sample_cnt
  );

endinterface

// File: rtl/result_slot.sv
// One-entry valid/ready holding register. A load into a full slot that is not
// draining this cycle is dropped and raises a sticky overrun flag.
module result_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr_ovr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             rdy,
  output logic [WIDTH-1:0] data,
  output logic             vld,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;
  logic             ovr_q, ovr_d;
  logic             drain;

  always_comb begin
    drain  = vld_q & rdy;
    data_d = data_q;
    vld_d  = vld_q & ~rdy;
    ovr_d  = ovr_q;
    if (load) begin
      // Draining frees the slot in the same cycle, so back-to-back results are lossless.
      if (!vld_q || drain) begin
        data_d = load_data;
        vld_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
    if (clr_ovr) ovr_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_q <= '0;
      vld_q  <= 1'b0;
      ovr_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
      ovr_q  <= ovr_d;
    end
  end

  assign data    = data_q;
  assign vld     = vld_q;
  assign overrun = ovr_q;

endmodule

// File: rtl/sample_averager.sv
// Block averager: sums 2**LOG2_AVG signed samples, then hands sum and floor
// mean to a one-entry result slot. Accumulation never stalls on the consumer.
module sample_averager
  import sample_averager_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int LOG2_AVG   = DEF_LOG2_AVG
) (
  input logic              clk,
  input logic              rstn,
  sample_averager_if.slave bus
);

  localparam int ACC_WIDTH = acc_width(DATA_WIDTH, LOG2_AVG);
  localparam logic [LOG2_AVG-1:0] CNT_LAST = '1;

  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic signed [ACC_WIDTH-1:0]  sample_ext, final_sum;
  logic signed [DATA_WIDTH-1:0] mean;
  logic [LOG2_AVG-1:0]          cnt_q, cnt_d;
  logic                         take, done;
  logic [ACC_WIDTH+DATA_WIDTH-1:0] slot_data;

  always_comb begin
    sample_ext = {{LOG2_AVG{bus.data_in[DATA_WIDTH-1]}}, bus.data_in};
    final_sum  = acc_q + sample_ext;
    // Arithmetic shift gives the floor mean; it always fits back in DATA_WIDTH.
    mean       = DATA_WIDTH'(final_sum >>> LOG2_AVG);
    take       = bus.data_in_vld & ~bus.clear;
    done       = take & (cnt_q == CNT_LAST);
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    if (bus.clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (take) begin
      acc_d = done ? '0 : final_sum;
      cnt_d = cnt_q + LOG2_AVG'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  result_slot #(
    .WIDTH(ACC_WIDTH + DATA_WIDTH)
  ) u_slot (
    .clk       (clk),
    .rstn      (rstn),
    .clr_ovr   (bus.clear),
    .load      (done),
    .load_data ({final_sum, mean}),
    .rdy       (bus.avg_out_rdy),
    .data      (slot_data),
    .vld       (bus.avg_out_vld),
    .overrun   (bus.overrun)
  );

  assign bus.sum_out    = slot_data[ACC_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
  assign bus.avg_out    = slot_data[DATA_WIDTH-1:0];
  assign bus.sample_cnt = cnt_q;

endmodule

// File: tb/tb_sample_averager.sv
// Directed plus random bench for sample_averager (16-bit samples, blocks of 4),
// checked every cycle against a queue-based block/slot reference model.
module tb_sample_averager;

  localparam int DW = 16;
  localparam int L2 = 2;
  localparam int N  = 4;

  logic clk;
  logic rstn;
  int   total;
  int   bad;

  // Reference model: samples of the open block, plus the output slot contents.
  int   blk[$];
  bit   m_vld;
  bit   m_ovr;
  int   m_sum;

  sample_averager_if #(.DATA_WIDTH(DW), .LOG2_AVG(L2)) bus ();

  sample_averager #(.DATA_WIDTH(DW), .LOG2_AVG(L2)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int fmean(input int s);
    if (s >= 0) return s / N;
    return -((-s + N - 1) / N);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit v, input int d, input bit r, input bit c);
    int s;
    if (!rstn) begin
      blk.delete();
      m_vld = 0; m_ovr = 0; m_sum = 0;
      return;
    end
    if (c) begin
      blk.delete();
      m_ovr = 0;
    end
    if (m_vld && r) m_vld = 0;
    if (v && !c) begin
      blk.push_back(d);
      if (blk.size() == N) begin
        s = 0;
        foreach (blk[i]) s += blk[i];
        blk.delete();
        if (!m_vld) begin
          m_vld = 1;
          m_sum = s;
        end else begin
          m_ovr = 1;
        end
      end
    end
  endtask

  task automatic step(input bit v, input int d, input bit r, input bit c);
    bus.data_in     = DW'(d);
    bus.data_in_vld = v;
    bus.avg_out_rdy = r;
    bus.clear       = c;
    @(posedge clk);
    model_edge(v, d, r, c);
    #1;
    chk("vld", int'(bus.avg_out_vld), int'(m_vld));
    chk("overrun", int'(bus.overrun), int'(m_ovr));
    chk("sample_cnt", int'(bus.sample_cnt), blk.size());
    if (m_vld) begin
      chk("sum_out", int'($signed(bus.sum_out)), m_sum);
      chk("avg_out", int'($signed(bus.avg_out)), fmean(m_sum));
    end
  endtask

  task automatic feed(input int d, input bit r);
    step(1'b1, d, r, 1'b0);
  endtask

  initial begin
    int cnt;
    total = 0; bad = 0;
    rstn = 1'b0;
    bus.data_in = '0; bus.data_in_vld = 1'b0;
    bus.avg_out_rdy = 1'b0; bus.clear = 1'b0;

    // 1. Reset state, then a basic block with rdy=1.
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_sum", int'(bus.sum_out), 0);
    chk("rst_avg", int'(bus.avg_out), 0);
    chk("rst_vld", int'(bus.avg_out_vld), 0);
    chk("rst_ovr", int'(bus.overrun), 0);
    chk("rst_cnt", int'(bus.sample_cnt), 0);
    rstn = 1'b1;
    feed(10, 1); feed(20, 1); feed(30, 1);
    chk("t1_pre_vld", int'(bus.avg_out_vld), 0);
    feed(40, 1);
    chk("t1_sum", int'($signed(bus.sum_out)), 100);
    chk("t1_avg", int'($signed(bus.avg_out)), 25);
    chk("t1_vld", int'(bus.avg_out_vld), 1);
    step(0, 0, 1, 0);
    chk("t1_vld_drop", int'(bus.avg_out_vld), 0);

    // 2. Signed floor and extreme negative block.
    feed(-1, 1); feed(-2, 1); feed(-2, 1); feed(-2, 1);
    chk("t2_sum_neg", int'($signed(bus.sum_out)), -7);
    chk("t2_avg_neg", int'($signed(bus.avg_out)), -2);
    for (int i = 0; i < N; i++) feed(-32768, 1);
    chk("t2_sum_min", int'($signed(bus.sum_out)), -131072);
    chk("t2_avg_min", int'($signed(bus.avg_out)), -32768);
    step(0, 0, 1, 0);

    // 3. Random gaps, then backpressure for 10 cycles.
    cnt = 0;
    while (cnt < N) begin
      if ($urandom_range(0, 2) == 0) begin
        feed($urandom_range(0, 65535) - 32768, 0);
        cnt++;
      end else begin
        step(0, $urandom_range(0, 65535), 0, 0);
      end
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
    chk("t3_held_vld", int'(bus.avg_out_vld), 1);
    step(0, 0, 1, 0);
    chk("t3_accept", int'(bus.avg_out_vld), 0);

    // 4. Overrun on a full slot; clear drops the flag but keeps the slot.
    for (int i = 1; i <= 8; i++) feed(i, 0);
    chk("t4_sum", int'($signed(bus.sum_out)), 10);
    chk("t4_ovr", int'(bus.overrun), 1);
    step(0, 0, 0, 1);
    chk("t4_clr_ovr", int'(bus.overrun), 0);
    chk("t4_clr_sum", int'($signed(bus.sum_out)), 10);
    chk("t4_clr_vld", int'(bus.avg_out_vld), 1);
    step(0, 0, 1, 0);

    // 5. Drain and load on the same edge.
    for (int i = 1; i <= 7; i++) feed(i, 0);
    feed(8, 1);
    chk("t5_sum", int'($signed(bus.sum_out)), 26);
    chk("t5_vld", int'(bus.avg_out_vld), 1);
    chk("t5_ovr", int'(bus.overrun), 0);
    step(0, 0, 1, 0);

    // 6. clear wins over a same-cycle sample; reset drops a pending result.
    feed(1, 0); feed(2, 0);
    step(1, 99, 0, 1);
    for (int i = 0; i < N; i++) feed(5, 0);
    chk("t6_clr_sum", int'($signed(bus.sum_out)), 20);
    feed(5, 0); feed(5, 0);
    rstn = 1'b0;
    step(0, 0, 0, 0);
    rstn = 1'b1;
    chk("t6_rst_vld", int'(bus.avg_out_vld), 0);
    chk("t6_rst_cnt", int'(bus.sample_cnt), 0);
    for (int i = 0; i < N; i++) feed(5, 0);
    chk("t6_rst_sum", int'($signed(bus.sum_out)), 20);

    // Random soak: samples, gaps, backpressure and occasional clear.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 65535) - 32768,
           $urandom_range(0, 2) != 0, $urandom_range(0, 24) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
